muldiv_arbiter: RTL and testbench

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_rr_pick.sv | 18 +
 rtl/muldiv_arbiter.sv | 155 +++++++++++++++
 tb/tb_muldiv_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the two-requester mul/div arbiter.
package muldiv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NumReq = 2;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/muldiv_rr_pick.sv
// Two-way round-robin picker: ptr_i is the last granted requester, so the other one wins a tie.
module muldiv_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Arbitrates two requesters onto one shared mul/div unit.
// Optional result reuse cache enabled by defining MULDIV_ARB_REUSE_EN.
module muldiv_arbiter
  import muldiv_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq*3-1:0]    req_op_i,
  input  logic [NumReq*XLEN-1:0] req_a_i,
  input  logic [NumReq*XLEN-1:0] req_b_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [NumReq-1:0]      rsp_valid_o,
  input  logic [NumReq-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]        rsp_data_o,
  output logic                   mdu_start_o,
  output logic                   mdu_div_o,
  output logic [2:0]             mdu_op_o,
  output logic [XLEN-1:0]        mdu_a_o,
  output logic [XLEN-1:0]        mdu_b_o,
  output logic                   mdu_stall_o,
  input  logic                   mdu_done_i,
  input  logic [XLEN-1:0]        mdu_result_i,
  output logic [NumReq*XLEN-1:0] grant_cnt_o
);

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [XLEN-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [1:0]      pick;
  logic [1:0]      gnt_vec;
  logic            gnt_any;
  logic            gnt_id;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            hit;
  logic [XLEN-1:0] hit_res;

  muldiv_rr_pick u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick)
  );

  // Grants only happen in IDLE and never while reset is asserted.
  assign gnt_any = (state_q == StIdle) && rst_ni && (|req_valid_i);
  assign gnt_vec = gnt_any ? pick : 2'b00;
  assign gnt_id  = gnt_vec[1];
  assign sel_op  = gnt_id ? req_op_i[5:3] : req_op_i[2:0];
  assign sel_a   = gnt_id ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
  assign sel_b   = gnt_id ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];

`ifdef MULDIV_ARB_REUSE_EN
  logic            c_vld_q;
  logic [2:0]      c_op_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_res_q;

  assign hit     = c_vld_q && (c_op_q == sel_op) && (c_a_q == sel_a) && (c_b_q == sel_b);
  assign hit_res = c_res_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_vld_q <= 1'b0;
      c_op_q  <= '0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_res_q <= '0;
    end else if (state_q == StWait && mdu_done_i) begin
      c_vld_q <= 1'b1;
      c_op_q  <= op_q;
      c_a_q   <= a_q;
      c_b_q   <= b_q;
      c_res_q <= mdu_result_i;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = hit ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mdu_done_i) state_d = StResp;
      StResp:  if (rsp_ready_i[id_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    id_d   = id_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt0_d = cnt0_q + {{(XLEN-1){1'b0}}, gnt_vec[0]};
    cnt1_d = cnt1_q + {{(XLEN-1){1'b0}}, gnt_vec[1]};
    if (gnt_any) begin
      ptr_d = gnt_id;
      id_d  = gnt_id;
      op_d  = sel_op;
      a_d   = sel_a;
      b_d   = sel_b;
      if (hit) res_d = hit_res;
    end
    if (state_q == StWait && mdu_done_i) res_d = mdu_result_i;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == StResp) rsp_valid_o[id_q] = 1'b1;
    mdu_start_o = (state_q == StIssue);
    mdu_stall_o = (state_q == StWait) || (state_q == StResp);
  end

  assign req_ready_o = gnt_vec;
  assign rsp_data_o  = res_q;
  assign mdu_div_o   = op_q[2];
  assign mdu_op_o    = op_q;
  assign mdu_a_o     = a_q;
  assign mdu_b_o     = b_q;
  assign grant_cnt_o = {cnt1_q, cnt0_q};

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed self-checking bench for muldiv_arbiter with a simple behavioural mul/div unit.
module tb_muldiv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [5:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_data;
  logic        mdu_start, mdu_div, mdu_stall;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic [63:0] grant_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int left = 0;
  int mdu_lat = 34;
  int start0;

  always #5 clk = ~clk;

  muldiv_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .mdu_start_o  (mdu_start),
    .mdu_div_o    (mdu_div),
    .mdu_op_o     (mdu_op),
    .mdu_a_o      (mdu_a),
    .mdu_b_o      (mdu_b),
    .mdu_stall_o  (mdu_stall),
    .mdu_done_i   (mdu_done),
    .mdu_result_i (mdu_result),
    .grant_cnt_o  (grant_cnt)
  );

  function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] p;
    case (op)
      3'd0: unit_calc = a * b;
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); unit_calc = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); unit_calc = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; unit_calc = p[63:32]; end
      3'd4: unit_calc = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      3'd5: unit_calc = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: unit_calc = (b == 0) ? a : 32'($signed(a) % $signed(b));
      default: unit_calc = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Shared unit model: one-cycle done pulse mdu_lat cycles after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left <= 0;
      mdu_done <= 1'b0;
      mdu_result <= '0;
    end else begin
      mdu_done <= 1'b0;
      if (mdu_start) left <= mdu_lat;
      else if (left > 0) begin
        left <= left - 1;
        if (left == 1) begin
          mdu_done <= 1'b1;
          mdu_result <= unit_calc(mdu_op, mdu_a, mdu_b);
        end
      end
    end
  end

  always @(posedge clk) if (mdu_start) start_cnt <= start_cnt + 1;

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200 && rsp_valid == 2'b00; i++) @(negedge clk);
  endtask

  task automatic accept(input logic [1:0] who);
    rsp_ready = who;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_cmp++; if ({rsp_valid, mdu_start, mdu_stall} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {rsp_valid, mdu_start, mdu_stall}); end
    n_cmp++; if ({rsp_data, mdu_a, mdu_b, mdu_op} !== 99'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {rsp_data, mdu_a, mdu_b, mdu_op}); end
    n_cmp++; if (grant_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", grant_cnt); end
    apply_reset();
  endtask

  task automatic test_single_mul();
    start0 = start_cnt;
    req_valid = 2'b01; req_op = 6'd0; req_a = {32'd0, 32'd7}; req_b = {32'd0, 32'd6};
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mul_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++; if ({mdu_start, mdu_div, mdu_a, mdu_b} !== {1'b1, 1'b0, 32'd7, 32'd6}) begin n_fail++; $display("FAIL mul_issue: got %h want %h", {mdu_start, mdu_div, mdu_a, mdu_b}, {1'b1, 1'b0, 32'd7, 32'd6}); end
    wait_rsp();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL mul_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd42) begin n_fail++; $display("FAIL mul_rsp_data: got %0d want 42", rsp_data); end
    n_cmp++; if (start_cnt - start0 !== 1) begin n_fail++; $display("FAIL mul_start_once: got %0d want 1", start_cnt - start0); end
    accept(2'b01);
    n_cmp++; if ({rsp_valid, mdu_stall} !== 3'b000) begin n_fail++; $display("FAIL mul_idle: got %b want 000", {rsp_valid, mdu_stall}); end
    n_cmp++; if (grant_cnt !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL mul_cnt: got %h want %h", grant_cnt, {32'd0, 32'd1}); end
  endtask

  task automatic test_tie();
    apply_reset();
    req_valid = 2'b11; req_op = {3'd4, 3'd0};
    req_a = {32'd21, 32'd3}; req_b = {32'd3, 32'd5};
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL tie_first: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b01;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL tie_busy: got %b want 00", req_ready); end
    wait_rsp();
    n_cmp++; if ({rsp_valid, rsp_data} !== {2'b10, 32'd7}) begin n_fail++; $display("FAIL tie_rsp1: got %h want %h", {rsp_valid, rsp_data}, {2'b10, 32'd7}); end
    accept(2'b01);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL tie_other_ready: got %b want 10", rsp_valid); end
    accept(2'b10);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL tie_second: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp();
    n_cmp++; if ({rsp_valid, rsp_data} !== {2'b01, 32'd15}) begin n_fail++; $display("FAIL tie_rsp0: got %h want %h", {rsp_valid, rsp_data}, {2'b01, 32'd15}); end
    accept(2'b01);
    n_cmp++; if (grant_cnt !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL tie_cnt: got %h want %h", grant_cnt, {32'd1, 32'd1}); end
  endtask

  task automatic test_hold();
    req_valid = 2'b01; req_op = 6'd6; req_a = {32'd0, 32'd17}; req_b = {32'd0, 32'd5};
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({mdu_stall, rsp_valid, rsp_data} !== {1'b1, 2'b01, 32'd2}) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %h want %h", i, {mdu_stall, rsp_valid, rsp_data}, {1'b1, 2'b01, 32'd2});
      end
      @(negedge clk);
    end
    accept(2'b01);
    n_cmp++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", mdu_stall); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 2'b01; req_op = 6'd0; req_a = {32'd0, 32'd9}; req_b = {32'd0, 32'd9};
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    n_cmp++; if (mdu_stall !== 1'b1) begin n_fail++; $display("FAIL rstwait_in_wait: got %b want 1", mdu_stall); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mdu_stall, mdu_start, rsp_valid, req_ready} !== 6'd0) begin n_fail++; $display("FAIL rstwait_ctl: got %b want 0", {mdu_stall, mdu_start, rsp_valid, req_ready}); end
    n_cmp++; if ({mdu_a, mdu_b, mdu_op, mdu_div, rsp_data, grant_cnt} !== 164'd0) begin n_fail++; $display("FAIL rstwait_data: got %h want 0", {mdu_a, mdu_b, mdu_op, mdu_div, rsp_data, grant_cnt}); end
    req_valid = 2'b01; req_op = 6'd4; req_a = {32'd0, 32'hFFFF_FFEC}; req_b = {32'd0, 32'd3};
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rstwait_no_grant: got %b want 00", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstwait_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp();
    n_cmp++; if ({rsp_valid, rsp_data} !== {2'b01, 32'hFFFF_FFFA}) begin n_fail++; $display("FAIL rstwait_div: got %h want %h", {rsp_valid, rsp_data}, {2'b01, 32'hFFFF_FFFA}); end
    accept(2'b01);
  endtask

  task automatic test_wrap();
    force dut.cnt1_q = 32'hFFFF_FFFF;
    #1 release dut.cnt1_q;
    #1;
    n_cmp++; if (grant_cnt[63:32] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", grant_cnt[63:32]); end
    @(negedge clk);
    req_valid = 2'b10; req_op = {3'd0, 3'd0}; req_a = {32'd2, 32'd0}; req_b = {32'd3, 32'd0};
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wrap_grant: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++; if (grant_cnt !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL wrap_cnt: got %h want %h", grant_cnt, {32'd0, 32'd1}); end
    wait_rsp();
    n_cmp++; if ({rsp_valid, rsp_data} !== {2'b10, 32'd6}) begin n_fail++; $display("FAIL wrap_rsp: got %h want %h", {rsp_valid, rsp_data}, {2'b10, 32'd6}); end
    accept(2'b10);
  endtask

  task automatic test_repeat();
    apply_reset();
    mdu_lat = 8;
    req_valid = 2'b01; req_op = 6'd5; req_a = {32'd0, 32'd100}; req_b = {32'd0, 32'd7};
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp();
    n_cmp++; if (rsp_data !== 32'd14) begin n_fail++; $display("FAIL repeat_first: got %0d want 14", rsp_data); end
    accept(2'b01);
    start0 = start_cnt;
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL repeat_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
`ifdef MULDIV_ARB_REUSE_EN
    n_cmp++; if ({rsp_valid, mdu_start, rsp_data} !== {2'b01, 1'b0, 32'd14}) begin n_fail++; $display("FAIL reuse_hit: got %h want %h", {rsp_valid, mdu_start, rsp_data}, {2'b01, 1'b0, 32'd14}); end
    n_cmp++; if (start_cnt !== start0) begin n_fail++; $display("FAIL reuse_no_start: got %0d want %0d", start_cnt, start0); end
`else
    n_cmp++; if ({rsp_valid, mdu_start} !== {2'b00, 1'b1}) begin n_fail++; $display("FAIL repeat_issue: got %b want 001", {rsp_valid, mdu_start}); end
    wait_rsp();
    n_cmp++; if (rsp_data !== 32'd14) begin n_fail++; $display("FAIL repeat_second: got %0d want 14", rsp_data); end
`endif
    accept(2'b01);
    n_cmp++; if (grant_cnt !== {32'd0, 32'd2}) begin n_fail++; $display("FAIL repeat_cnt: got %h want %h", grant_cnt, {32'd0, 32'd2}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_mul();
    test_tie();
    test_hold();
    test_reset_mid_wait();
    test_wrap();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
